// File: rtl/line_window_buffer.sv
// line_window_buffer: chain of kernelSize-1 line memories that turns a raster
// pixel stream into one vertical window column (kernelSize pixels) per input
// pixel, with a runtime line width of up to maxImageWidth pixels.
//
// Ports:
//   i_clk, i_rst        rising-edge clock, synchronous active-high reset
//   i_width             line width; sampled on the first pixel after reset and on i_sof
//                       (0 or > maxImageWidth selects maxImageWidth)
//   i_sof               start of frame, qualified by i_data_valid (row 0, column 0)
//   i_data/i_data_valid input pixel and strobe; no backpressure
//   o_data              window column; slice 0 = current pixel, slice k = k rows above
//   o_data_valid        column valid (only once kernelSize-1 lines are buffered)
//   o_col, o_eol        column index of o_data, last column of the line
//
// Latency is one cycle from accepted pixel to all outputs.
// Optional build macro LINE_WINDOW_ZERO_PAD_EN: columns are valid from the first
// pixel of a frame, and rows not yet buffered read as zero (top-border padding).
module line_window_buffer #(
  parameter int dataWidth     = 8,
  parameter int maxImageWidth = 512,
  parameter int kernelSize    = 3
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [$clog2(maxImageWidth):0]        i_width,
  input  logic                                  i_sof,
  input  logic [dataWidth-1:0]                  i_data,
  input  logic                                  i_data_valid,
  output logic [kernelSize*dataWidth-1:0]       o_data,
  output logic                                  o_data_valid,
  output logic [$clog2(maxImageWidth)-1:0]      o_col,
  output logic                                  o_eol
);

  localparam int CW = $clog2(maxImageWidth);  // column pointer width
  localparam int WW = CW + 1;                 // width field can hold maxImageWidth itself
  localparam int NL = kernelSize - 1;         // number of line memories
  localparam int RW = $clog2(kernelSize);     // rows-filled counter, 0..kernelSize-1

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Registered state
  state_t                         state_q, state_d;
  logic [CW-1:0]                  col_q, col_d;
  logic [RW-1:0]                  rows_q, rows_d;
  logic [WW-1:0]                  w_lat_q, w_lat_d;
  logic                           need_w_q, need_w_d;   // width not yet latched since reset
  logic [kernelSize*dataWidth-1:0] o_data_q, o_data_d;
  logic                           o_vld_q, o_vld_d;
  logic [CW-1:0]                  o_col_q, o_col_d;
  logic                           o_eol_q, o_eol_d;

  // Line memories; contents are never reset
  logic [dataWidth-1:0] mem [NL][maxImageWidth];
  logic [dataWidth-1:0] rd  [NL];

  // Effective per-pixel context after a start-of-frame override
  logic          sof;
  logic [WW-1:0] w_sane;
  logic [WW-1:0] w_cur;
  logic [CW-1:0] col_eff;
  logic [RW-1:0] rows_eff;
  state_t        state_eff;
  logic          last_col;
  logic          wr_en;

  assign sof       = i_sof & i_data_valid;
  assign w_sane    = (i_width == '0 || i_width > WW'(maxImageWidth)) ? WW'(maxImageWidth) : i_width;
  // A freshly sampled width applies to the very pixel that samples it
  assign w_cur     = (need_w_q | sof) ? w_sane : w_lat_q;
  assign col_eff   = sof ? '0 : col_q;
  assign rows_eff  = sof ? '0 : rows_q;
  assign state_eff = sof ? FILL : state_q;
  assign last_col  = ({1'b0, col_eff} == (w_cur - WW'(1)));
  assign wr_en     = i_data_valid & ~i_rst;

  // Read-before-write: the old contents at this column feed both the
  // next memory in the chain and the output column.
  for (genvar g = 0; g < NL; g++) begin : g_rd
    assign rd[g] = mem[g][col_eff];
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    rows_d   = rows_q;
    w_lat_d  = w_lat_q;
    need_w_d = need_w_q;
    o_data_d = o_data_q;
    o_vld_d  = 1'b0;
    o_col_d  = o_col_q;
    o_eol_d  = 1'b0;

    if (i_data_valid) begin
      w_lat_d  = w_cur;
      need_w_d = 1'b0;

      o_data_d[dataWidth-1:0] = i_data;
      for (int k = 1; k < kernelSize; k++) begin
        o_data_d[k*dataWidth +: dataWidth] = rd[k-1];
`ifdef LINE_WINDOW_ZERO_PAD_EN
        if (k > int'(rows_eff)) begin
          o_data_d[k*dataWidth +: dataWidth] = '0;
        end
`endif
      end

`ifdef LINE_WINDOW_ZERO_PAD_EN
      o_vld_d = 1'b1;
`else
      o_vld_d = (state_eff == STREAM);
`endif
      o_col_d = col_eff;
      o_eol_d = last_col & o_vld_d;

      if (last_col) begin
        col_d  = '0;
        rows_d = (rows_eff == RW'(NL)) ? rows_eff : rows_eff + RW'(1);
        // Filling the last line memory switches to streaming; only sof/reset leave it
        state_d = (rows_d == RW'(NL)) ? STREAM : state_eff;
      end else begin
        col_d   = col_eff + CW'(1);
        rows_d  = rows_eff;
        state_d = state_eff;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= FILL;
      col_q    <= '0;
      rows_q   <= '0;
      w_lat_q  <= WW'(maxImageWidth);
      need_w_q <= 1'b1;
      o_data_q <= '0;
      o_vld_q  <= 1'b0;
      o_col_q  <= '0;
      o_eol_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      rows_q   <= rows_d;
      w_lat_q  <= w_lat_d;
      need_w_q <= need_w_d;
      o_data_q <= o_data_d;
      o_vld_q  <= o_vld_d;
      o_col_q  <= o_col_d;
      o_eol_q  <= o_eol_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[0][col_eff] <= i_data;
      for (int k = 1; k < NL; k++) begin
        mem[k][col_eff] <= rd[k-1];
      end
    end
  end

  assign o_data       = o_data_q;
  assign o_data_valid = o_vld_q;
  assign o_col        = o_col_q;
  assign o_eol        = o_eol_q;

endmodule

// File: tb/tb_line_window_buffer.sv
module tb_line_window_buffer;

  localparam int DW   = 8;
  localparam int MAXW = 512;
  localparam int K    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [9:0]    width = 10'd4;
  logic          sof = 1'b0;
  logic [DW-1:0] din = '0;
  logic          dvld = 1'b0;
  logic [K*DW-1:0] dout;
  logic          ovld;
  logic [8:0]    ocol;
  logic          oeol;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  line_window_buffer #(
    .dataWidth(DW),
    .maxImageWidth(MAXW),
    .kernelSize(K)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_width(width),
    .i_sof(sof),
    .i_data(din),
    .i_data_valid(dvld),
    .o_data(dout),
    .o_data_valid(ovld),
    .o_col(ocol),
    .o_eol(oeol)
  );

  // One clock cycle of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic r, input logic v, input logic s, input logic [DW-1:0] d);
    @(negedge clk);
    rst  = r;
    dvld = v;
    sof  = s;
    din  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, 8'hAA);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    checks++; if (dout !== '0)    begin failures++; $display("FAIL reset o_data got %h want 0", dout); end
    checks++; if (ovld !== 1'b0)  begin failures++; $display("FAIL reset o_data_valid got %b want 0", ovld); end
    checks++; if (ocol !== '0)    begin failures++; $display("FAIL reset o_col got %0d want 0", ocol); end
    checks++; if (oeol !== 1'b0)  begin failures++; $display("FAIL reset o_eol got %b want 0", oeol); end
  endtask

  // Width 4, pixels 1..16 with sof on pixel 1, optionally with idle cycles between pixels.
  task automatic test_stream(input bit gaps);
    logic [K*DW-1:0] exp_d;
    logic            exp_v;
    width = 10'd4;
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int p = 1; p <= 16; p++) begin
      step(1'b0, 1'b1, p == 1, DW'(p));
      exp_v = (p >= 9);
      exp_d = {DW'(p - 8), DW'(p - 4), DW'(p)};
      checks++;
      if (ovld !== exp_v) begin
        failures++; $display("FAIL stream gaps=%0b p=%0d valid got %b want %b", gaps, p, ovld, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (dout !== exp_d) begin
          failures++; $display("FAIL stream gaps=%0b p=%0d data got %h want %h", gaps, p, dout, exp_d);
        end
        checks++;
        if (ocol !== 9'((p - 1) % 4)) begin
          failures++; $display("FAIL stream gaps=%0b p=%0d col got %0d want %0d", gaps, p, ocol, (p - 1) % 4);
        end
        checks++;
        if (oeol !== (((p - 1) % 4) == 3)) begin
          failures++; $display("FAIL stream gaps=%0b p=%0d eol got %b want %b", gaps, p, oeol, ((p - 1) % 4) == 3);
        end
      end
      if (gaps) begin
        step(1'b0, 1'b0, 1'b0, 8'hEE);
        checks++;
        if (ovld !== 1'b0 || oeol !== 1'b0) begin
          failures++; $display("FAIL gap p=%0d valid/eol got %b/%b want 0/0", p, ovld, oeol);
        end
        if (exp_v) begin
          checks++;
          if (dout !== exp_d) begin
            failures++; $display("FAIL gap hold p=%0d data got %h want %h", p, dout, exp_d);
          end
        end
      end
    end
  endtask

  // Width 0 and width 600 both select a 512-pixel line.
  task automatic test_width_limits();
    int ws[2] = '{0, 600};
    for (int i = 0; i < 2; i++) begin
      width = 10'(ws[i]);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      for (int p = 1; p <= 3 * MAXW; p++) begin
        step(1'b0, 1'b1, p == 1, DW'(p));
        if (p == 2 * MAXW) begin
          checks++;
          if (ovld !== 1'b0) begin
            failures++; $display("FAIL width=%0d p=%0d valid got %b want 0", ws[i], p, ovld);
          end
        end
        if (p == 2 * MAXW + 1) begin
          checks++;
          if (ovld !== 1'b1 || ocol !== 9'd0) begin
            failures++; $display("FAIL width=%0d first valid got v=%b col=%0d want v=1 col=0", ws[i], ovld, ocol);
          end
          checks++;
          if (dout !== {DW'(p - 1024), DW'(p - 512), DW'(p)}) begin
            failures++; $display("FAIL width=%0d first column got %h want %h", ws[i], dout,
                                 {DW'(p - 1024), DW'(p - 512), DW'(p)});
          end
        end
        if (p == 3 * MAXW) begin
          checks++;
          if (oeol !== 1'b1 || ocol !== 9'd511) begin
            failures++; $display("FAIL width=%0d line end got eol=%b col=%0d want eol=1 col=511", ws[i], oeol, ocol);
          end
        end
      end
    end
  endtask

  // Restart of a width-4 frame by sof on pixel 11.
  task automatic test_mid_sof();
    width = 10'd4;
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int p = 1; p <= 19; p++) begin
      step(1'b0, 1'b1, (p == 1) || (p == 11), DW'(p));
      if (p == 10) begin
        checks++;
        if (ovld !== 1'b1) begin failures++; $display("FAIL midsof p=10 valid got %b want 1", ovld); end
      end
      if (p == 11) begin
        checks++;
        if (ocol !== 9'd0 || ovld !== 1'b0) begin
          failures++; $display("FAIL midsof p=11 got col=%0d v=%b want col=0 v=0", ocol, ovld);
        end
      end
      if (p > 11 && p < 19) begin
        checks++;
        if (ovld !== 1'b0) begin failures++; $display("FAIL midsof p=%0d valid got %b want 0", p, ovld); end
      end
      if (p == 19) begin
        checks++;
        if (ovld !== 1'b1 || ocol !== 9'd0 || dout !== {8'd11, 8'd15, 8'd19}) begin
          failures++; $display("FAIL midsof p=19 got v=%b col=%0d data=%h want v=1 col=0 data=0b0f13", ovld, ocol, dout);
        end
      end
    end
  endtask

  // One-cycle reset in STREAM (with a pixel that must be dropped), then a frame without sof.
  task automatic test_rst_mid();
    width = 10'd4;
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int p = 1; p <= 10; p++) step(1'b0, 1'b1, p == 1, DW'(p));
    checks++;
    if (ovld !== 1'b1) begin failures++; $display("FAIL rstmid pre-reset valid got %b want 1", ovld); end
    step(1'b1, 1'b1, 1'b0, 8'h77);
    checks++;
    if (dout !== '0 || ovld !== 1'b0 || ocol !== '0 || oeol !== 1'b0) begin
      failures++; $display("FAIL rstmid outputs got data=%h v=%b col=%0d eol=%b want all 0", dout, ovld, ocol, oeol);
    end
    for (int p = 1; p <= 9; p++) begin
      step(1'b0, 1'b1, 1'b0, DW'(100 + p));
      if (p < 9) begin
        checks++;
        if (ovld !== 1'b0) begin failures++; $display("FAIL rstmid refill p=%0d valid got %b want 0", p, ovld); end
      end else begin
        checks++;
        if (ovld !== 1'b1 || ocol !== 9'd0 || dout !== {8'd101, 8'd105, 8'd109}) begin
          failures++; $display("FAIL rstmid p=9 got v=%b col=%0d data=%h want v=1 col=0 data=65696d", ovld, ocol, dout);
        end
      end
    end
  endtask

  task automatic test_zero_pad();
    width = 10'd4;
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int p = 1; p <= 8; p++) begin
      step(1'b0, 1'b1, p == 1, DW'(p));
      if (p == 1) begin
        checks++;
        if (ovld !== 1'b1 || dout !== {8'd0, 8'd0, 8'd1}) begin
          failures++; $display("FAIL zpad p=1 got v=%b data=%h want v=1 data=000001", ovld, dout);
        end
      end
      if (p == 5) begin
        checks++;
        if (ovld !== 1'b1 || dout !== {8'd0, 8'd1, 8'd5}) begin
          failures++; $display("FAIL zpad p=5 got v=%b data=%h want v=1 data=000105", ovld, dout);
        end
      end
    end
  endtask

  initial begin
    test_reset();
`ifdef LINE_WINDOW_ZERO_PAD_EN
    test_zero_pad();
`else
    test_stream(1'b0);
    test_stream(1'b1);
    test_width_limits();
    test_mid_sof();
    test_rst_mid();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
